// File: rtl/right_shifter_sticky_pipe.sv
// rtl/right_shifter_sticky_pipe.sv - pipelined right shifter with sticky, valid/ready handshake and sideband tag
// Shift levels run MSB-first; a register bank closes every REG_EVERY levels and the last group.
module right_shifter_sticky_pipe #(
  parameter int W         = 15,
  parameter int SW        = $clog2(W) + 1,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [W-1:0]     i_in,
  input  logic [SW-1:0]    i_s,
  input  logic             i_padbit,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [W-1:0]     o_r,
  output logic             o_sticky,
  output logic [TAG_W-1:0] o_tag
);

  localparam int L = (SW + REG_EVERY - 1) / REG_EVERY;

  logic             en;
  logic [W-1:0]     d_q   [L];
  logic             st_q  [L];
  logic [SW-1:0]    s_q   [L];
  logic             pad_q [L];
  logic [TAG_W-1:0] tag_q [L];
  logic             v_q   [L];

  assign o_valid  = v_q[L-1];
  assign en       = ~o_valid | i_ready;
  assign o_ready  = en;
  assign o_r      = d_q[L-1];
  assign o_sticky = st_q[L-1];
  assign o_tag    = tag_q[L-1];

  for (genvar g = 0; g < L; g++) begin : g_stage
    localparam int HI = SW - 1 - g * REG_EVERY;
    localparam int LO = (HI - REG_EVERY + 1 < 0) ? 0 : HI - REG_EVERY + 1;

    logic [W-1:0]     d_in;
    logic [W-1:0]     d_nx;
    logic [W-1:0]     d_ld;
    logic             st_in;
    logic             st_nx;
    logic [SW-1:0]    s_in;
    logic             pad_in;
    logic [TAG_W-1:0] tag_in;
    logic             v_in;

    if (g == 0) begin : g_src
      assign d_in   = i_in;
      assign st_in  = 1'b0;
      assign s_in   = i_s;
      assign pad_in = i_padbit;
      assign tag_in = i_tag;
      assign v_in   = i_valid;
    end else begin : g_src
      assign d_in   = d_q[g-1];
      assign st_in  = st_q[g-1];
      assign s_in   = s_q[g-1];
      assign pad_in = pad_q[g-1];
      assign tag_in = tag_q[g-1];
      assign v_in   = v_q[g-1];
    end

    // Intermediate data is zero-filled so pad bits can never leak into sticky.
    always_comb begin
      d_nx  = d_in;
      st_nx = st_in;
      for (int k = HI; k >= LO; k--) begin
        if (s_in[k]) begin
          if ((1 << k) >= W) begin
            st_nx = st_nx | (|d_nx);
            d_nx  = '0;
          end else begin
            st_nx = st_nx | (|(d_nx & ~({W{1'b1}} << (1 << k))));
            d_nx  = d_nx >> (1 << k);
          end
        end
      end
    end

    // The pad fill is applied once, from the full shift amount, just before the output register.
    if (g == L - 1) begin : g_fill
      logic [W-1:0] fill;
      assign fill = (s_in >= SW'(W)) ? {W{1'b1}} : ~({W{1'b1}} >> s_in);
      assign d_ld = pad_in ? (d_nx | fill) : d_nx;
    end else begin : g_fill
      assign d_ld = d_nx;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        d_q[g]   <= '0;
        st_q[g]  <= 1'b0;
        s_q[g]   <= '0;
        pad_q[g] <= 1'b0;
        tag_q[g] <= '0;
        v_q[g]   <= 1'b0;
      end else if (en) begin
        d_q[g]   <= d_ld;
        st_q[g]  <= st_nx;
        s_q[g]   <= s_in;
        pad_q[g] <= pad_in;
        tag_q[g] <= tag_in;
        v_q[g]   <= v_in;
      end
    end
  end

endmodule

// File: tb/tb_right_shifter_sticky_pipe.sv
// tb/tb_right_shifter_sticky_pipe.sv - self-checking bench for right_shifter_sticky_pipe
module tb_right_shifter_sticky_pipe;

  typedef struct {
    logic [30:0] r;
    logic        st;
    logic [3:0]  tag;
    int          cyc;
  } exp_t;

  localparam int LAT_M = 3;
  localparam int LAT_A = 5;
  localparam int LAT_B = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        in_valid, in_ready, in_pad, out_valid, out_ready, out_sticky;
  logic [14:0] in_data, out_r;
  logic [4:0]  in_s;
  logic [3:0]  in_tag, out_tag;

  logic        a_valid, a_ready, a_pad, a_ovalid, a_st;
  logic [14:0] a_data, a_r;
  logic [4:0]  a_s;
  logic [3:0]  a_tag, a_otag;

  logic        b_valid, b_ready, b_pad, b_ovalid, b_st;
  logic [30:0] b_data, b_r;
  logic [5:0]  b_s;
  logic [3:0]  b_tag, b_otag;

  right_shifter_sticky_pipe #(.W(15), .REG_EVERY(2), .TAG_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(in_ready), .i_in(in_data),
    .i_s(in_s), .i_padbit(in_pad), .i_tag(in_tag), .o_valid(out_valid), .i_ready(out_ready),
    .o_r(out_r), .o_sticky(out_sticky), .o_tag(out_tag));

  right_shifter_sticky_pipe #(.W(15), .REG_EVERY(1), .TAG_W(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_ready(a_ready), .i_in(a_data),
    .i_s(a_s), .i_padbit(a_pad), .i_tag(a_tag), .o_valid(a_ovalid), .i_ready(1'b1),
    .o_r(a_r), .o_sticky(a_st), .o_tag(a_otag));

  right_shifter_sticky_pipe #(.W(31), .REG_EVERY(5), .TAG_W(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_ready), .i_in(b_data),
    .i_s(b_s), .i_padbit(b_pad), .i_tag(b_tag), .o_valid(b_ovalid), .i_ready(1'b1),
    .o_r(b_r), .o_sticky(b_st), .o_tag(b_otag));

  // Arithmetic reference: shift the value as a number, pad the vacated top bits, OR the lost low bits.
  function automatic exp_t model(input longint x, input int s, input bit pad, input int w,
                                 input logic [3:0] tag);
    exp_t   e;
    longint one = 1;
    longint m   = (one << w) - 1;
    longint r;
    if (s >= w) begin
      r    = pad ? m : 0;
      e.st = (x != 0);
    end else begin
      r    = (x >> s) | (pad ? (m & ~(m >> s)) : 0);
      e.st = ((x & ((one << s) - 1)) != 0);
    end
    e.r   = r[30:0];
    e.tag = tag;
    e.cyc = 0;
    return e;
  endfunction

  task automatic run_one(input logic [14:0] d, input logic [4:0] s, input logic p,
                         input logic [3:0] t, output logic [14:0] r, output logic st,
                         output logic [3:0] tg, output int lat);
    @(negedge clk);
    in_data = d; in_s = s; in_pad = p; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    lat = -1; r = 'x; st = 1'bx; tg = 'x;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        r = out_r; st = out_sticky; tg = out_tag; lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 0; in_data = 0; in_s = 0; in_pad = 0; in_tag = 0; out_ready = 1;
    a_valid = 0; a_data = 0; a_s = 0; a_pad = 0; a_tag = 0;
    b_valid = 0; b_data = 0; b_s = 0; b_pad = 0; b_tag = 0;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_r !== 15'h0) begin errors++; $display("FAIL reset_r got=%h exp=0", out_r); end
    checks++; if (out_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got=%b exp=0", out_sticky); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_tag got=%h exp=0", out_tag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_directed;
    logic [14:0] dv [5] = '{15'h00B5, 15'h0040, 15'h1234, 15'h0001, 15'h0000};
    logic [4:0]  sv [5] = '{5'd3, 5'd4, 5'd0, 5'd20, 5'd15};
    logic        pv [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [14:0] rv [5] = '{15'h0016, 15'h7804, 15'h1234, 15'h0000, 15'h7FFF};
    logic        stv[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [14:0] r;
    logic        st;
    logic [3:0]  tg, t;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      t = 4'($urandom);
      run_one(dv[i], sv[i], pv[i], t, r, st, tg, lat);
      checks++; if (lat != LAT_M) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT_M); end
      checks++; if (r !== rv[i]) begin errors++; $display("FAIL dir%0d_r got=%h exp=%h", i, r, rv[i]); end
      checks++; if (st !== stv[i]) begin errors++; $display("FAIL dir%0d_sticky got=%b exp=%b", i, st, stv[i]); end
      checks++; if (tg !== t) begin errors++; $display("FAIL dir%0d_tag got=%h exp=%h", i, tg, t); end
    end
  endtask

  task automatic test_back_to_back;
    logic [14:0] dat [8];
    logic [4:0]  sh  [8];
    logic        pd  [8];
    exp_t        q[$];
    exp_t        e;
    int          idx = 0;
    int          outc = 0;
    logic        stalled = 1'b0;
    logic [14:0] pr = 0;
    logic        pst = 0;
    logic [3:0]  ptg = 0;
    for (int i = 0; i < 8; i++) begin
      dat[i] = 15'($urandom); sh[i] = 5'($urandom_range(0, 31)); pd[i] = 1'($urandom);
    end
    @(negedge clk);
    for (int c = 0; c < 40 && outc < 8; c++) begin
      if (c > 0) @(negedge clk);
      in_valid = (idx < 8);
      if (idx < 8) begin
        in_data = dat[idx]; in_s = sh[idx]; in_pad = pd[idx]; in_tag = 4'(idx);
      end
      out_ready = !(c >= 5 && c <= 8);
      #1;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_r !== pr || out_sticky !== pst || out_tag !== ptg) begin
          errors++;
          $display("FAIL b2b_hold c=%0d got v=%b r=%h s=%b t=%h exp v=1 r=%h s=%b t=%h",
                   c, out_valid, out_r, out_sticky, out_tag, pr, pst, ptg);
        end
      end
      if (c >= 5 && c <= 8) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready c=%0d got=%b exp=0", c, in_ready); end
      end
      if (c >= 9) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_throughput c=%0d got=%b exp=1", c, out_valid); end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_spurious c=%0d got=valid exp=none", c);
        end else begin
          e = q.pop_front();
          if (out_tag !== e.tag || out_r !== e.r[14:0] || out_sticky !== e.st) begin
            errors++;
            $display("FAIL b2b_out%0d got r=%h s=%b t=%h exp r=%h s=%b t=%h",
                     outc, out_r, out_sticky, out_tag, e.r[14:0], e.st, e.tag);
          end
        end
        outc++;
      end
      if (in_valid && in_ready === 1'b1) begin
        q.push_back(model(longint'(dat[idx]), int'(sh[idx]), pd[idx], 15, 4'(idx)));
        idx++;
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      pr = out_r; pst = out_sticky; ptg = out_tag;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (outc != 8 || q.size() != 0) begin errors++; $display("FAIL b2b_count got=%0d exp=8", outc); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midstream;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 15'h7FFF; in_s = 5'd0; in_pad = 1'b0; in_tag = 4'(c + 1); out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_r !== 15'h7FFF) begin errors++; $display("FAIL rstmid_pre got v=%b r=%h exp v=1 r=7fff", out_valid, out_r); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    checks++; if (out_r !== 15'h0) begin errors++; $display("FAIL rstmid_r got=%h exp=0", out_r); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale c=%0d got=%b exp=0", c, out_valid); end
    end
  endtask

  task automatic test_random;
    exp_t qm[$];
    exp_t qa[$];
    exp_t qb[$];
    exp_t e;
    logic pending = 1'b0;
    int   cyc = 0;
    for (int n = 0; n < 5020; n++) begin
      @(negedge clk);
      if (n < 5000) begin
        if (!pending) begin
          in_valid = 1'($urandom); in_data = 15'($urandom); in_s = 5'($urandom_range(0, 31));
          in_pad = 1'($urandom); in_tag = 4'($urandom);
        end
        out_ready = ($urandom_range(0, 3) != 0);
        a_valid = ($urandom_range(0, 4) != 0); a_data = 15'($urandom); a_s = 5'($urandom_range(0, 31));
        a_pad = 1'($urandom); a_tag = 4'($urandom);
        b_valid = ($urandom_range(0, 4) != 0); b_data = 31'($urandom); b_s = 6'($urandom_range(0, 63));
        b_pad = 1'($urandom); b_tag = 4'($urandom);
      end else begin
        in_valid = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
      end
      #1;
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (qm.size() == 0) begin
          errors++; $display("FAIL rnd_m_spurious cyc=%0d got=valid exp=none", cyc);
        end else begin
          e = qm.pop_front();
          if (out_r !== e.r[14:0] || out_sticky !== e.st || out_tag !== e.tag) begin
            errors++;
            $display("FAIL rnd_m cyc=%0d got r=%h s=%b t=%h exp r=%h s=%b t=%h",
                     cyc, out_r, out_sticky, out_tag, e.r[14:0], e.st, e.tag);
          end
        end
      end
      if (in_valid && in_ready === 1'b1)
        qm.push_back(model(longint'(in_data), int'(in_s), in_pad, 15, in_tag));
      pending = in_valid && (in_ready !== 1'b1);
      if (a_ovalid === 1'b1) begin
        checks++;
        if (qa.size() == 0) begin
          errors++; $display("FAIL rnd_a_spurious cyc=%0d got=valid exp=none", cyc);
        end else begin
          e = qa.pop_front();
          if (a_r !== e.r[14:0] || a_st !== e.st || a_otag !== e.tag || cyc - e.cyc != LAT_A) begin
            errors++;
            $display("FAIL rnd_a cyc=%0d got r=%h s=%b t=%h lat=%0d exp r=%h s=%b t=%h lat=%0d",
                     cyc, a_r, a_st, a_otag, cyc - e.cyc, e.r[14:0], e.st, e.tag, LAT_A);
          end
        end
      end
      if (a_valid) begin
        e = model(longint'(a_data), int'(a_s), a_pad, 15, a_tag); e.cyc = cyc; qa.push_back(e);
      end
      if (b_ovalid === 1'b1) begin
        checks++;
        if (qb.size() == 0) begin
          errors++; $display("FAIL rnd_b_spurious cyc=%0d got=valid exp=none", cyc);
        end else begin
          e = qb.pop_front();
          if (b_r !== e.r || b_st !== e.st || b_otag !== e.tag || cyc - e.cyc != LAT_B) begin
            errors++;
            $display("FAIL rnd_b cyc=%0d got r=%h s=%b t=%h lat=%0d exp r=%h s=%b t=%h lat=%0d",
                     cyc, b_r, b_st, b_otag, cyc - e.cyc, e.r, e.st, e.tag, LAT_B);
          end
        end
      end
      if (b_valid) begin
        e = model(longint'(b_data), int'(b_s), b_pad, 31, b_tag); e.cyc = cyc; qb.push_back(e);
      end
      cyc++;
    end
    checks++;
    if (qm.size() != 0 || qa.size() != 0 || qb.size() != 0) begin
      errors++; $display("FAIL rnd_drain got left=%0d/%0d/%0d exp=0/0/0", qm.size(), qa.size(), qb.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/right_shifter_sticky_pipe.md
Name: right_shifter_sticky_pipe

Overview:
- Parametrised, pipelined successor of the combinational 15-bit right shifter with sticky used in the posit adder datapath (fraction alignment before add).
- Generalises width, adds a full shift range (amount >= width) and selectable register insertion.
- Adds a valid/ready handshake with backpressure and a sideband tag that travels with each operand.
- Sits between the exponent/regime difference stage and the fraction adder.

Parameters:
W, 15, data width of i_in/o_r (>=2)
SW, $clog2(W)+1, width of shift amount i_s; must satisfy 2^SW > W
REG_EVERY, 2, number of shift levels per pipeline register (>=1)
TAG_W, 4, width of sideband tag carried alongside data (>=1)

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous, active-high reset
i_valid  input  1  operand valid
o_ready  output  1  block can accept operand this cycle
i_in  input  W  operand to shift
i_s  input  SW  right-shift amount, unsigned
i_padbit  input  1  fill bit for vacated MSBs (0 logical, sign for arithmetic)
i_tag  input  TAG_W  sideband tag, unchanged
o_valid  output  1  result valid
i_ready  input  1  downstream accepts result
o_r  output  W  shifted result
o_sticky  output  1  OR of all input bits shifted out
o_tag  output  TAG_W  tag of the result

Behaviour:
- Levels: LEVELS = SW. Level k (k = SW-1 down to 0) shifts by 2^k when i_s[k]=1, filling with i_padbit. Sticky accumulates the OR of the bits discarded at each level.
- Shifts >= W: o_r = {W{i_padbit}}, o_sticky = |i_in. Pad bits never contribute to sticky.
- i_s = 0: o_r = i_in, o_sticky = 0.
- Pipeline: a register bank (data, partial sticky, remaining shift bits, padbit, tag, valid) follows every REG_EVERY levels. The final level group always ends in a register, so outputs are registered.
- Latency: L = ceil(SW/REG_EVERY) cycles from accepted input to o_valid (3 for defaults W=15, SW=5).
- Handshake: transfer in when i_valid && o_ready; transfer out when o_valid && i_ready.
- Global stage enable en = ~o_valid | i_ready; o_ready = en. All stages advance together when en=1 and hold when en=0.
- Bubbles are not collapsed. Throughput is 1 per cycle with no backpressure.
- Input data is ignored when i_valid=0; the valid bit propagates 0. Data registers may update but o_r/o_sticky/o_tag are only meaningful when o_valid=1.
- Outputs hold stable while o_valid=1 and i_ready=0.
- Simultaneous stall and new input: input is not accepted (o_ready=0). Upstream must hold it.
- Reset (any time, including mid-stream): all valid bits to 0, o_r=0, o_sticky=0, o_tag=0, o_ready=1 (combinational from o_valid=0). In-flight operands are discarded.
- No combinational path from i_valid/i_in to outputs. o_ready depends combinationally only on i_ready and the registered o_valid.

Test Plan:
- W=15, i_in=15'h00B5, i_s=3, i_padbit=0, i_ready=1 -> after 3 cycles o_valid=1, o_r=15'h0016, o_sticky=1, o_tag echoes input tag.
- i_in=15'h0040, i_s=4, i_padbit=1 -> o_r=15'h7804, o_sticky=0. Then i_s=0 with i_in=15'h1234 -> o_r=15'h1234, o_sticky=0.
- Range: i_in=15'h0001, i_s=20, pad 0 -> o_r=0, o_sticky=1. i_in=0, i_s=15, pad 1 -> o_r=15'h7FFF, o_sticky=0.
- Streaming with backpressure: issue 8 back-to-back operands with tags 0..7 and hold i_ready=0 for cycles 5-8. Require o_ready=0 during the stall, held outputs stable, no loss or duplication, results in tag order, and 1/cycle throughput after release.
- Reset mid-stream with 3 operands in flight: assert i_rst asynchronously between clock edges. o_valid and o_r drop to 0 immediately, and no stale result appears after deassertion.
- Random compare against a golden model, 10k vectors with REG_EVERY in {1,2,5} and W in {15,31}: o_r and o_sticky match exactly, latency = ceil(SW/REG_EVERY).
